mem_arbiter2: RTL and testbench

Two-master arbiter for the native PicoRV32 memory bus (valid/ready, addr/wdata/wstrb/rdata). It shares one memory slave port between master 0 (the CPU core) and master 1 (a DMA or debug master), using round-robin arbitration and a one-transfer grant. A per-transfer timeout watchdog returns an error response when the slave never answers. It sits between the core and the memory model / address decoder in the simulation and FPGA tops.

---
 rtl/mem_arbiter2.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter2.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter2.sv
// mem_arbiter2 -- two-master round-robin arbiter for the PicoRV32 native
// memory bus (valid/ready, addr/wdata/wstrb/rdata).
//
// Master 0 (CPU core) and master 1 (DMA/debug) share one slave port. A grant
// covers exactly one transfer, and one IDLE cycle always follows it. A
// per-transfer watchdog ends a transfer with an error response when the
// slave stays silent for TIMEOUT grant cycles.
//
// Parameters:
//   TIMEOUT    grant cycles without s_ready before a forced completion (0 = off)
//   ERR_RDATA  read data returned on a forced completion
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   m0_valid/addr/wdata/wstrb        master 0 request (wstrb 0 = read)
//   m0_ready, m0_rdata               master 0 completion pulse and read data
//   m1_*                             same for master 1
//   s_valid/addr/wdata/wstrb         request to slave (all 0 in IDLE)
//   s_ready, s_rdata                 slave completion and read data
//   grant                            one-hot owner (bit0 = m0, bit1 = m1)
//   timeout                          one-cycle pulse on a forced completion
module mem_arbiter2 #(
    parameter int          TIMEOUT   = 256,
    parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout
);

    // Width must stay at least 1 even when the watchdog is disabled.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // cnt holds the number of silent grant cycles already elapsed, so the
    // TIMEOUT-th cycle is the one where cnt == TIMEOUT-1.
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        G0,
        G1
    } state_t;

    state_t           state, state_next;
    logic             last, last_next;   // 0 = m0 granted last, 1 = m1
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             sel_valid;
    logic             expired;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 1'b1;               // m0 wins the first tie
            cnt   <= '0;
        end else begin
            state <= state_next;
            last  <= last_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        // NOTE: every output and next-state value gets a default first, so no
        // path through the case statement can leave one unassigned (latch).
        state_next = state;
        last_next  = last;
        cnt_next   = cnt;
        s_valid    = 1'b0;
        s_addr     = '0;
        s_wdata    = '0;
        s_wstrb    = '0;
        grant      = 2'b00;
        m0_ready   = 1'b0;
        m1_ready   = 1'b0;
        m0_rdata   = s_rdata;
        m1_rdata   = s_rdata;
        timeout    = 1'b0;
        sel_valid  = 1'b0;
        expired    = 1'b0;

        case (state)
            IDLE: begin
                cnt_next = '0;
                // On a tie, grant whichever master was not served last.
                if (m0_valid && (!m1_valid || last)) begin
                    state_next = G0;
                    last_next  = 1'b0;
                end else if (m1_valid) begin
                    state_next = G1;
                    last_next  = 1'b1;
                end
            end

            G0, G1: begin
                if (state == G0) begin
                    sel_valid = m0_valid;
                    s_addr    = m0_addr;
                    s_wdata   = m0_wdata;
                    s_wstrb   = m0_wstrb;
                    grant     = 2'b01;
                end else begin
                    sel_valid = m1_valid;
                    s_addr    = m1_addr;
                    s_wdata   = m1_wdata;
                    s_wstrb   = m1_wstrb;
                    grant     = 2'b10;
                end

                // A slave answer in the last allowed cycle still counts as normal.
                expired = (TIMEOUT != 0) && !s_ready && (cnt == CNT_LAST);
                s_valid = sel_valid && !expired;
                timeout = sel_valid && expired;

                if (!sel_valid) begin
                    // Master withdrew its request: drop the grant silently.
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (s_ready || expired) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    if (state == G0) begin
                        m0_ready = 1'b1;
                        if (expired) m0_rdata = ERR_RDATA;
                    end else begin
                        m1_ready = 1'b1;
                        if (expired) m1_rdata = ERR_RDATA;
                    end
                end else if (TIMEOUT != 0) begin
                    cnt_next = cnt + 1'b1;
                end
            end

            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter2.sv
// tb_mem_arbiter2 -- directed scenarios followed by a randomized run, all
// checked cycle by cycle against a transaction-level model of the arbiter
// (owner index, previous owner, count of silent grant cycles).
module tb_mem_arbiter2;

    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk;
    logic        rst_n;
    logic        mv [2];
    logic [31:0] ma [2];
    logic [31:0] mw [2];
    logic [3:0]  ms [2];
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic [1:0]  grant;
    logic        timeout;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the bus (-1 = nobody), who owned it last,
    // and how many grant cycles have passed without a slave answer.
    int   owner;
    int   prev;
    int   stall;
    logic exp_rdy [2];

    mem_arbiter2 #(.TIMEOUT(TO), .ERR_RDATA(ERR)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_valid (mv[0]),
        .m0_addr  (ma[0]),
        .m0_wdata (mw[0]),
        .m0_wstrb (ms[0]),
        .m0_ready (m0_ready),
        .m0_rdata (m0_rdata),
        .m1_valid (mv[1]),
        .m1_addr  (ma[1]),
        .m1_wdata (mw[1]),
        .m1_wstrb (ms[1]),
        .m1_ready (m1_ready),
        .m1_rdata (m1_rdata),
        .s_valid  (s_valid),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_ready  (s_ready),
        .s_rdata  (s_rdata),
        .grant    (grant),
        .timeout  (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = -1;
        prev  = 1;
        stall = 0;
        exp_rdy[0] = 1'b0;
        exp_rdy[1] = 1'b0;
    endtask

    task automatic new_req(input int i);
        mv[i] = 1'b1;
        ma[i] = $urandom & 32'hFFFF_FFFC;
        mw[i] = $urandom;
        ms[i] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    endtask

    // Let combinational outputs settle, then compare every output with the model.
    task automatic eval();
        logic        ev, eto;
        logic [31:0] ea, ew, erd;
        logic [3:0]  es;
        logic [1:0]  eg;
        #2;
        ev = 1'b0; eto = 1'b0; ea = '0; ew = '0; es = '0; eg = 2'b00; erd = s_rdata;
        exp_rdy[0] = 1'b0;
        exp_rdy[1] = 1'b0;
        if (rst_n && owner >= 0) begin
            ea = ma[owner];
            ew = mw[owner];
            es = ms[owner];
            eg = (owner == 0) ? 2'b01 : 2'b10;
            if (mv[owner]) begin
                if (s_ready) begin
                    ev = 1'b1;
                    exp_rdy[owner] = 1'b1;
                end else if (stall + 1 == TO) begin
                    eto = 1'b1;
                    erd = ERR;
                    exp_rdy[owner] = 1'b1;
                end else begin
                    ev = 1'b1;
                end
            end
        end
        check("s_valid", 32'(s_valid), 32'(ev));
        check("s_addr", s_addr, ea);
        check("s_wdata", s_wdata, ew);
        check("s_wstrb", 32'(s_wstrb), 32'(es));
        check("grant", 32'(grant), 32'(eg));
        check("m0_ready", 32'(m0_ready), 32'(exp_rdy[0]));
        check("m1_ready", 32'(m1_ready), 32'(exp_rdy[1]));
        check("timeout", 32'(timeout), 32'(eto));
        if (exp_rdy[0]) check("m0_rdata", m0_rdata, erd);
        if (exp_rdy[1]) check("m1_rdata", m1_rdata, erd);
    endtask

    // Cross the clock edge and advance the model by one cycle.
    task automatic adv();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (owner < 0) begin
            if (mv[0] && mv[1]) owner = (prev == 0) ? 1 : 0;
            else if (mv[0])     owner = 0;
            else if (mv[1])     owner = 1;
            if (owner >= 0) prev = owner;
            stall = 0;
        end else if (!mv[owner] || exp_rdy[owner]) begin
            owner = -1;
            stall = 0;
        end else begin
            stall++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        mv[0]   = 1'b0; mv[1] = 1'b0;
        ma[0]   = '0;   ma[1] = '0;
        mw[0]   = '0;   mw[1] = '0;
        ms[0]   = '0;   ms[1] = '0;
        s_ready = 1'b0;
        s_rdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [1:0] glog [$];
    logic [1:0] prev_g;
    int         done_cnt [2];
    int         obs_cnt [2];

    initial begin
        do_reset();

        // Reset state.
        eval();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_s_valid", 32'(s_valid), 32'h0);
        adv();

        // Single read from m0; slave answers one cycle after s_valid.
        mv[0] = 1'b1; ma[0] = 32'h100; mw[0] = 32'h0; ms[0] = 4'h0;
        eval();
        check("t1_idle_grant", 32'(grant), 32'h0);
        adv();
        eval();
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_s_addr", s_addr, 32'h100);
        adv();
        s_ready = 1'b1; s_rdata = 32'h12345678;
        eval();
        check("t1_m0_ready", 32'(m0_ready), 32'h1);
        check("t1_m0_rdata", m0_rdata, 32'h12345678);
        check("t1_m1_ready", 32'(m1_ready), 32'h0);
        adv();
        mv[0] = 1'b0; s_ready = 1'b0;
        eval();
        check("t1_back_idle", 32'(grant), 32'h0);
        adv();

        // Simultaneous requests right after reset: m0 first, then m1.
        do_reset();
        mv[0] = 1'b1; ma[0] = 32'h200; mw[0] = 32'hA5A5A5A5; ms[0] = 4'hF;
        mv[1] = 1'b1; ma[1] = 32'h300; mw[1] = 32'h0;        ms[1] = 4'h0;
        eval();
        adv();
        s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
        eval();
        check("t2_grant_a", 32'(grant), 32'h1);
        check("t2_addr_a", s_addr, 32'h200);
        check("t2_wdata_a", s_wdata, 32'hA5A5A5A5);
        check("t2_wstrb_a", 32'(s_wstrb), 32'hF);
        adv();
        mv[0] = 1'b0; s_ready = 1'b0;
        eval();
        check("t2_bubble", 32'(grant), 32'h0);
        adv();
        s_ready = 1'b1; s_rdata = 32'hCAFE0300;
        eval();
        check("t2_grant_b", 32'(grant), 32'h2);
        check("t2_addr_b", s_addr, 32'h300);
        check("t2_m1_rdata", m1_rdata, 32'hCAFE0300);
        adv();
        mv[1] = 1'b0; s_ready = 1'b0;

        // Continuous contention: four transfers each, slave answers in the
        // second grant cycle.
        glog.delete();
        prev_g = 2'b00;
        for (int i = 0; i < 2; i++) begin
            done_cnt[i] = 0;
            obs_cnt[i]  = 0;
            new_req(i);
        end
        for (int cyc = 0; cyc < 200 && !(done_cnt[0] == 4 && done_cnt[1] == 4); cyc++) begin
            s_ready = (owner >= 0 && stall >= 1);
            s_rdata = $urandom;
            eval();
            obs_cnt[0] += int'(m0_ready);
            obs_cnt[1] += int'(m1_ready);
            if (grant != 2'b00 && prev_g == 2'b00) glog.push_back(grant);
            prev_g = grant;
            adv();
            for (int i = 0; i < 2; i++) begin
                if (exp_rdy[i]) begin
                    done_cnt[i]++;
                    if (done_cnt[i] < 4) new_req(i);
                    else mv[i] = 1'b0;
                end
            end
        end
        s_ready = 1'b0;
        check("t3_grant_count", 32'(glog.size()), 32'd8);
        for (int i = 0; i < glog.size(); i++)
            check($sformatf("t3_grant_%0d", i), 32'(glog[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
        check("t3_m0_pulses", 32'(obs_cnt[0]), 32'd4);
        check("t3_m1_pulses", 32'(obs_cnt[1]), 32'd4);
        eval();
        adv();

        // Silent slave: m1 read is errored in its 8th grant cycle.
        mv[1] = 1'b1; ma[1] = 32'h400; ms[1] = 4'h0;
        eval();
        adv();
        for (int k = 1; k <= TO; k++) begin
            s_rdata = $urandom;
            eval();
            if (k < TO) begin
                check("t4_no_timeout", 32'(timeout), 32'h0);
                check("t4_s_valid", 32'(s_valid), 32'h1);
            end else begin
                check("t4_s_valid_forced", 32'(s_valid), 32'h0);
                check("t4_m1_ready", 32'(m1_ready), 32'h1);
                check("t4_m1_rdata", m1_rdata, 32'hDEADBEEF);
                check("t4_timeout", 32'(timeout), 32'h1);
            end
            adv();
        end
        mv[1] = 1'b0;
        mv[0] = 1'b1; ma[0] = 32'h404; ms[0] = 4'h0;
        eval();
        adv();
        s_ready = 1'b1; s_rdata = 32'h5555AAAA;
        eval();
        check("t4_m0_ready", 32'(m0_ready), 32'h1);
        check("t4_m0_rdata", m0_rdata, 32'h5555AAAA);
        check("t4_m0_no_timeout", 32'(timeout), 32'h0);
        adv();
        mv[0] = 1'b0; s_ready = 1'b0;
        eval();
        adv();

        // Slave answers exactly in the TIMEOUT-th cycle: normal completion.
        mv[0] = 1'b1; ma[0] = 32'h500; ms[0] = 4'h0;
        eval();
        adv();
        for (int k = 1; k <= TO; k++) begin
            s_ready = (k == TO);
            s_rdata = 32'h7000_0000 + 32'(k);
            eval();
            if (k == TO) begin
                check("t5_m0_ready", 32'(m0_ready), 32'h1);
                check("t5_m0_rdata", m0_rdata, 32'h7000_0008);
                check("t5_timeout", 32'(timeout), 32'h0);
                check("t5_s_valid", 32'(s_valid), 32'h1);
            end
            adv();
        end
        mv[0] = 1'b0; s_ready = 1'b0;
        eval();
        adv();

        // Reset pulsed during a stalled G1; afterwards an m0/m1 tie goes to m0.
        mv[1] = 1'b1; ma[1] = 32'h600; ms[1] = 4'h0;
        eval();
        adv();
        eval();
        adv();
        mv[0] = 1'b1; ma[0] = 32'h604; ms[0] = 4'h0;
        rst_n = 1'b0;
        model_reset();
        eval();
        check("t6_s_valid", 32'(s_valid), 32'h0);
        check("t6_grant", 32'(grant), 32'h0);
        check("t6_m1_ready", 32'(m1_ready), 32'h0);
        check("t6_s_addr", s_addr, 32'h0);
        adv();
        rst_n = 1'b1;
        eval();
        adv();
        s_ready = 1'b1; s_rdata = $urandom;
        eval();
        check("t6_first_grant", 32'(grant), 32'h1);
        adv();
        mv[0] = 1'b0; s_ready = 1'b0;
        eval();
        adv();
        s_ready = 1'b1; s_rdata = $urandom;
        eval();
        check("t6_second_grant", 32'(grant), 32'h2);
        adv();
        mv[1] = 1'b0; s_ready = 1'b0;
        eval();
        adv();

        // Randomized traffic: protocol-respecting masters with occasional
        // aborts, and a slave that answers randomly (also while idle).
        for (int cyc = 0; cyc < 3000; cyc++) begin
            s_ready = ($urandom_range(0, 9) < 3);
            s_rdata = $urandom;
            eval();
            adv();
            for (int i = 0; i < 2; i++) begin
                if (exp_rdy[i]) mv[i] = 1'b0;
                if (mv[i] && owner == i && $urandom_range(0, 49) == 0)
                    mv[i] = 1'b0;
                else if (!mv[i] && $urandom_range(0, 9) < 4)
                    new_req(i);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
